// File: rtl/fsbus_if.sv
// ---------------------------------------------------------------------------
// fsbus_if
//   Bundles the three Wishbone master ports and the shared flash/SSRAM slave
//   port that meet at fsbus_scheduler.
//
//   Master side (packed, master n in slice n):
//     m_cyc_i, m_stb_i, m_we_i, m_flash_i  [2:0]  request, strobe, write, target
//     m_adr_i [80:0]   27-bit address per master
//     m_sel_i [11:0]   4-bit byte enables per master
//     m_dat_i [95:0]   32-bit write data per master
//     m_ack_o [2:0]    per-master ack (owner only)
//     m_dat_o [31:0]   read data broadcast to all masters
//     gnt_o   [2:0]    one-hot current owner
//   Slave side:
//     s_cyc_o, s_stb_o, s_we_o, s_adr_o[26:0], s_sel_o[3:0], s_dat_o[31:0]
//     s_dat_i[31:0]    read data from the selected target
//     ssram_stb_o, flash_stb_o   strobe qualified per target
//     ssram_ack_i, flash_ack_i   per-target acks
//
//   Modport "slave" is the scheduler's view; "master" is the view of the
//   environment (masters plus targets) that drives the scheduler.
// ---------------------------------------------------------------------------
interface fsbus_if;
    logic [2:0]  m_cyc_i;
    logic [2:0]  m_stb_i;
    logic [2:0]  m_we_i;
    logic [2:0]  m_flash_i;
    logic [80:0] m_adr_i;
    logic [11:0] m_sel_i;
    logic [95:0] m_dat_i;
    logic [2:0]  m_ack_o;
    logic [31:0] m_dat_o;
    logic [2:0]  gnt_o;

    logic        s_cyc_o;
    logic        s_stb_o;
    logic        s_we_o;
    logic [26:0] s_adr_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_dat_o;
    logic [31:0] s_dat_i;
    logic        ssram_stb_o;
    logic        flash_stb_o;
    logic        ssram_ack_i;
    logic        flash_ack_i;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_flash_i, m_adr_i, m_sel_i, m_dat_i,
        input  s_dat_i, ssram_ack_i, flash_ack_i,
        output m_ack_o, m_dat_o, gnt_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
        output ssram_stb_o, flash_stb_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_flash_i, m_adr_i, m_sel_i, m_dat_i,
        output s_dat_i, ssram_ack_i, flash_ack_i,
        input  m_ack_o, m_dat_o, gnt_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
        input  ssram_stb_o, flash_stb_o
    );
endinterface

// File: rtl/fsbus_scheduler.sv
// ---------------------------------------------------------------------------
// fsbus_scheduler
//   Arbitrates three Wishbone masters (m0 = VGA, m1 = CPU, m2 = DMA) onto the
//   shared flash/SSRAM bus. m0 has fixed priority, m1/m2 share round-robin.
//   An owner that is being contended for may collect at most MAX_BURST acks
//   before it is forced off, and every ownership change passes through one
//   dead TURN cycle so the SSRAM and flash data drivers never overlap.
//
//   Ports:
//     sysclock   system clock, rising edge
//     rst_i      asynchronous active-high reset
//     bus        fsbus_if.slave (master ports, slave port, target strobes/acks)
//   Parameter:
//     MAX_BURST  acks per contended tenure, 1..255
// ---------------------------------------------------------------------------
module fsbus_scheduler #(
    parameter int unsigned MAX_BURST = 8
) (
    input  logic    sysclock,
    input  logic    rst_i,
    fsbus_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_e;

    // The ack that takes the count to MAX_BURST is the last one delivered.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_BURST - 1);
    localparam logic [7:0] HOLD_MAX  = 8'(MAX_BURST);

    state_e      state_q, state_d;
    logic [2:0]  gnt_q, gnt_d;
    logic        rr_q, rr_d;          // 0 favours m1, 1 favours m2
    logic        tgt_q, tgt_d;        // 1 = flash, latched at grant
    logic [7:0]  hold_cnt_q, hold_cnt_d;

    logic [2:0]  req;
    logic [2:0]  win;
    logic        others_req;
    logic        owner_drop;
    logic        owner_ack;
    logic        limit_hit;

    logic        stb;
    logic        we;
    logic [26:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;

    assign req        = bus.m_cyc_i;
    assign others_req = |(req & ~gnt_q);
    assign owner_drop = ~|(req & gnt_q);
    assign owner_ack  = (tgt_q ? bus.flash_ack_i : bus.ssram_ack_i) && (state_q == ST_GRANT);
    assign limit_hit  = owner_ack && others_req && (hold_cnt_q >= HOLD_LAST);

    // Winner among current requesters; only consumed in IDLE and TURN.
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        win = 3'b000;
        if (req[0]) begin
            win = 3'b001;
        end else if (req[1] && req[2]) begin
            win = rr_q ? 3'b100 : 3'b010;
        end else if (req[1]) begin
            win = 3'b010;
        end else if (req[2]) begin
            win = 3'b100;
        end
    end

    // State register (also holds grant, round-robin, target and hold count).
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge sysclock or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 3'b000;
            rr_q       <= 1'b0;
            tgt_q      <= 1'b0;
            hold_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_q       <= rr_d;
            tgt_q      <= tgt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_d       = rr_q;
        tgt_d      = tgt_q;
        hold_cnt_d = hold_cnt_q;

        case (state_q)
            ST_IDLE, ST_TURN: begin
                if (|win) begin
                    state_d    = ST_GRANT;
                    gnt_d      = win;
                    hold_cnt_d = 8'd0;
                    tgt_d      = |(win & bus.m_flash_i);
                    // Point round-robin at the master that did not win.
                    if (win[1]) begin
                        rr_d = 1'b1;
                    end else if (win[2]) begin
                        rr_d = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = 3'b000;
                end
            end

            ST_GRANT: begin
                // Only contended tenures are metered; a lone owner holds freely.
                if (owner_ack && others_req && (hold_cnt_q < HOLD_MAX)) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
                if (owner_drop || limit_hit) begin
                    state_d = ST_TURN;
                    gnt_d   = 3'b000;
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = 3'b000;
            end
        endcase
    end

    // Output logic: owner mux onto the slave port, target qualification, acks.
    always_comb begin
        stb = 1'b0;
        we  = 1'b0;
        adr = '0;
        sel = '0;
        dat = '0;
        if (state_q == ST_GRANT) begin
            for (int i = 0; i < 3; i++) begin
                if (gnt_q[i]) begin
                    stb = bus.m_stb_i[i];
                    we  = bus.m_we_i[i];
                    adr = bus.m_adr_i[27*i +: 27];
                    sel = bus.m_sel_i[4*i +: 4];
                    dat = bus.m_dat_i[32*i +: 32];
                end
            end
        end

        bus.gnt_o       = gnt_q;
        bus.s_cyc_o     = (state_q == ST_GRANT);
        bus.s_stb_o     = stb;
        bus.s_we_o      = we;
        bus.s_adr_o     = adr;
        bus.s_sel_o     = sel;
        bus.s_dat_o     = dat;
        bus.ssram_stb_o = stb & ~tgt_q;
        bus.flash_stb_o = stb & tgt_q;
        bus.m_ack_o     = gnt_q & {3{owner_ack}};
        bus.m_dat_o     = bus.s_dat_i;
    end

endmodule
